// File: rtl/timer_unit.sv
// Programmable 8-bit timer peripheral: prescaled counter with compare match,
// sticky match flag and a one-cycle interrupt pulse, behind a small register port.
module timer_unit #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              timer_interrupt
);

  localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_PRESCALE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_COMPARE  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_COUNT    = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(4);

  logic              en;
  logic              auto_reload;
  logic              irq_en;
  logic [DATA_W-1:0] prescale;
  logic [DATA_W-1:0] compare;
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] psc;
  logic              status;

  logic wr_ctrl, wr_psc, wr_cmp, wr_cnt, wr_sts;
  logic tick, match;

  always_comb begin
    wr_ctrl = wr_en && (addr == A_CTRL);
    wr_psc  = wr_en && (addr == A_PRESCALE);
    wr_cmp  = wr_en && (addr == A_COMPARE);
    wr_cnt  = wr_en && (addr == A_COUNT);
    wr_sts  = wr_en && (addr == A_STATUS);
    // A tick coinciding with a PRESCALE/COUNT write, or a CTRL write that
    // clears en, is dropped entirely: no increment, no match, no pulse.
    tick    = en && (psc == prescale) && !wr_psc && !wr_cnt
              && !(wr_ctrl && !wr_data[0]);
    match   = tick && (count == compare);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en              <= 1'b0;
      auto_reload     <= 1'b0;
      irq_en          <= 1'b0;
      prescale        <= '0;
      compare         <= '1;
      count           <= '0;
      psc             <= '0;
      status          <= 1'b0;
      timer_interrupt <= 1'b0;
    end else begin
      timer_interrupt <= match && irq_en;

      if (wr_psc || wr_cnt || !en || (psc == prescale)) begin
        psc <= '0;
      end else begin
        psc <= psc + DATA_W'(1);
      end

      if (wr_ctrl) begin
        {irq_en, auto_reload, en} <= wr_data[2:0];
      end else if (match && !auto_reload) begin
        en <= 1'b0;
      end

      if (wr_psc) prescale <= wr_data;
      if (wr_cmp) compare  <= wr_data;

      if (wr_cnt) begin
        count <= wr_data;
      end else if (tick) begin
        if (match) begin
          if (auto_reload) count <= '0;
        end else begin
          count <= count + DATA_W'(1);
        end
      end

      if (match) begin
        status <= 1'b1;
      end else if (wr_sts && wr_data[0]) begin
        status <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      A_CTRL:     rd_data[2:0] = {irq_en, auto_reload, en};
      A_PRESCALE: rd_data = prescale;
      A_COMPARE:  rd_data = compare;
      A_COUNT:    rd_data = count;
      A_STATUS:   rd_data[0] = status;
      default:    rd_data = '0;
    endcase
  end

endmodule
